// File: rtl/matinv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matinv_pkg : widths, Q2.14 limits, FSM states and matrix record for
//              the inverse-matrix vector applier.   Rev 1.0
// ----------------------------------------------------------------------------
package matinv_pkg;

  localparam int W_IN      = 16;
  localparam int W_PROD    = 32;
  localparam int W_ACC     = 34;
  localparam int RND_SHIFT = 14;

  localparam logic [W_IN-1:0] Q_MAX = 16'h7FFF;
  localparam logic [W_IN-1:0] Q_MIN = 16'h8000;

  localparam logic signed [W_ACC-1:0] RND_HALF = 34'sd8192;
  localparam logic signed [W_ACC-1:0] SAT_HI   = 34'sd32767;
  localparam logic signed [W_ACC-1:0] SAT_LO   = -34'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RND  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [W_IN-1:0] a;
    logic signed [W_IN-1:0] b;
    logic signed [W_IN-1:0] c;
    logic signed [W_IN-1:0] d;
    logic                   err;
  } mat_t;

endpackage
`default_nettype wire

// File: rtl/matinv_vec_apply_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matinv_vec_apply_if : matrix load, vector in and result out channels.
//                       Rev 1.0
// ----------------------------------------------------------------------------
interface matinv_vec_apply_if;
  import matinv_pkg::*;

  logic                   mat_valid;
  logic signed [W_IN-1:0] a_inv;
  logic signed [W_IN-1:0] b_inv;
  logic signed [W_IN-1:0] c_inv;
  logic signed [W_IN-1:0] d_inv;
  logic                   mat_error;
  logic                   vec_valid;
  logic                   vec_ready;
  logic signed [W_IN-1:0] y0;
  logic signed [W_IN-1:0] y1;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [W_IN-1:0] x0;
  logic signed [W_IN-1:0] x1;
  logic                   out_sat;
  logic                   out_err;

  modport master (
    output mat_valid, a_inv, b_inv, c_inv, d_inv, mat_error,
    output vec_valid, y0, y1, out_ready,
    input  vec_ready, out_valid, x0, x1, out_sat, out_err
  );

  modport slave (
    input  mat_valid, a_inv, b_inv, c_inv, d_inv, mat_error,
    input  vec_valid, y0, y1, out_ready,
    output vec_ready, out_valid, x0, x1, out_sat, out_err
  );

endinterface
`default_nettype wire

// File: rtl/round_sat_q6_28_to_q2_14.sv
`default_nettype none
// ----------------------------------------------------------------------------
// round_sat_q6_28_to_q2_14 : round half toward +inf, saturate to Q2.14.
//                            Rev 1.0
// ----------------------------------------------------------------------------
module round_sat_q6_28_to_q2_14
  import matinv_pkg::*;
(
  input  logic signed [W_ACC-1:0] acc,
  output logic        [W_IN-1:0]  q,
  output logic                    sat
);

  logic signed [W_ACC-1:0] sum_w;
  logic signed [W_ACC-1:0] r_w;

  always_comb begin
    sum_w = acc + RND_HALF;
    r_w   = sum_w >>> RND_SHIFT;
    sat   = 1'b0;
    q     = r_w[W_IN-1:0];
    if (r_w > SAT_HI) begin
      q   = Q_MAX;
      sat = 1'b1;
    end else if (r_w < SAT_LO) begin
      q   = Q_MIN;
      sat = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matinv_vec_apply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matinv_vec_apply : x = A^-1 * y with one shared 16x16 multiplier over
//                    four cycles, then round/saturate to Q2.14.   Rev 1.0
// ----------------------------------------------------------------------------
module matinv_vec_apply
  import matinv_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  matinv_vec_apply_if.slave  bus
);

  state_t                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic                    have_mat_q, have_mat_d;
  mat_t                    pend_q, pend_d;
  mat_t                    act_q, act_d;
  logic signed [W_IN-1:0]  y0_q, y0_d, y1_q, y1_d;
  logic signed [W_ACC-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [W_IN-1:0]         x0_q, x0_d, x1_q, x1_d;
  logic                    sat_q, sat_d, err_q, err_d;

  logic signed [W_IN-1:0]   mul_a, mul_b;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_ACC-1:0]  prod_ext;
  logic [W_IN-1:0]          q0, q1;
  logic                     s0, s1;

  // Step k selects the matrix element; odd steps pair with y1.
  always_comb begin
    case (k_q)
      2'd0:    mul_a = act_q.a;
      2'd1:    mul_a = act_q.b;
      2'd2:    mul_a = act_q.c;
      default: mul_a = act_q.d;
    endcase
    mul_b    = k_q[0] ? y1_q : y0_q;
    prod     = mul_a * mul_b;
    prod_ext = {{(W_ACC-W_PROD){prod[W_PROD-1]}}, prod};
  end

  round_sat_q6_28_to_q2_14 u_rs0 (.acc(acc0_q), .q(q0), .sat(s0));
  round_sat_q6_28_to_q2_14 u_rs1 (.acc(acc1_q), .q(q1), .sat(s1));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    have_mat_d = have_mat_q;
    pend_d     = pend_q;
    act_d      = act_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    sat_d      = sat_q;
    err_d      = err_q;

    if (bus.mat_valid) begin
      pend_d     = '{a: bus.a_inv, b: bus.b_inv, c: bus.c_inv,
                     d: bus.d_inv, err: bus.mat_error};
      have_mat_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // act takes pend_q, so a same-cycle mat_valid lands on the next vector.
        if (bus.vec_valid && have_mat_q) begin
          act_d   = pend_q;
          y0_d    = bus.y0;
          y1_d    = bus.y1;
          k_d     = 2'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        case (k_q)
          2'd0:    acc0_d = prod_ext;
          2'd1:    acc0_d = acc0_q + prod_ext;
          2'd2:    acc1_d = prod_ext;
          default: acc1_d = acc1_q + prod_ext;
        endcase
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_RND;
      end
      ST_RND: begin
        if (act_q.err) begin
          x0_d  = '0;
          x1_d  = '0;
          sat_d = 1'b0;
          err_d = 1'b1;
        end else begin
          x0_d  = q0;
          x1_d  = q1;
          sat_d = s0 | s1;
          err_d = 1'b0;
        end
        state_d = ST_OUT;
      end
      default: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      have_mat_q <= 1'b0;
      pend_q     <= '0;
      act_q      <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      have_mat_q <= have_mat_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
    end
  end

  assign bus.vec_ready = (state_q == ST_IDLE) && have_mat_q;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.x0        = x0_q;
  assign bus.x1        = x1_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_err   = err_q;

endmodule
`default_nettype wire
